// File: rtl/fifo_level.sv
// fifo_level: single-clock show-ahead FIFO with occupancy count, almost-full/almost-empty flags and optional sticky error flags
//
// Optional feature macro: FIFO_LEVEL_ERR_EN
//   defined     -> overflow/underflow are sticky registers, cleared by err_clr (err_clr wins over a set)
//   not defined -> overflow/underflow tied 0, err_clr ignored
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   wr           in   write request
//   rd           in   read request
//   w_data       in   [B-1:0] write data
//   err_clr      in   clears sticky error flags
//   r_data       out  [B-1:0] head-of-queue word (combinational from memory)
//   full         out  count == 2**W
//   empty        out  count == 0
//   almost_full  out  count >= AF_LVL
//   almost_empty out  count <= AE_LVL
//   count        out  [W:0] words stored
//   overflow     out  sticky: write dropped because full
//   underflow    out  sticky: read attempted while empty (and no write)
module fifo_level #(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AF_LVL = 2**W - 2,
    parameter int AE_LVL = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    input  logic         err_clr,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);
    localparam logic [W:0] DEPTH = (W+1)'(2**W);
    localparam logic [W:0] AF    = (W+1)'(AF_LVL);
    localparam logic [W:0] AE    = (W+1)'(AE_LVL);

    logic [B-1:0] r_mem [2**W];
    logic [W-1:0] r_wptr, r_rptr;
    logic [W:0]   r_count;
    logic         r_full, r_empty, r_af, r_ae;
    logic         w_do_wr, w_do_rd;
    logic [W:0]   w_cnt_nxt;

    // A write on a full FIFO is still accepted when a read frees the head slot this cycle.
    assign w_do_rd   = rd & ~r_empty;
    assign w_do_wr   = wr & (~r_full | rd);
    assign w_cnt_nxt = (w_do_wr & ~w_do_rd) ? r_count + (W+1)'(1) :
                       (~w_do_wr & w_do_rd) ? r_count - (W+1)'(1) : r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + W'(1);
            if (w_do_rd) r_rptr <= r_rptr + W'(1);
            r_count <= w_cnt_nxt;
            r_full  <= w_cnt_nxt == DEPTH;
            r_empty <= w_cnt_nxt == '0;
            r_af    <= w_cnt_nxt >= AF;
            r_ae    <= w_cnt_nxt <= AE;
        end
    end

    // Storage is not reset; contents are logically discarded by the pointer reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wptr] <= w_data;
    end

    assign r_data       = r_mem[r_rptr];
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

`ifdef FIFO_LEVEL_ERR_EN
    logic r_ovf, r_unf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= err_clr ? 1'b0 : r_ovf | (wr & r_full & ~rd);
            r_unf <= err_clr ? 1'b0 : r_unf | (rd & r_empty & ~wr);
        end
    end

    assign overflow  = r_ovf;
    assign underflow = r_unf;
`else
    logic w_unused;

    assign w_unused  = err_clr;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: scoreboard bench for fifo_level (B=8, W=4, AF_LVL=12, AE_LVL=2)
module tb_fifo_level;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int         n_vec = 0, n_err = 0;
    logic [7:0] q[$];
    logic       e_ov = 1'b0, e_un = 1'b0;
    logic [8:0] e_lvl;

`ifdef FIFO_LEVEL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    fifo_level #(.B(8), .W(4), .AF_LVL(12), .AE_LVL(2)) dut (
        .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .w_data(w_data),
        .err_clr(err_clr), .r_data(r_data), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] lvl_of(input int n);
        return {5'(n), n == 16, n == 0, n >= 12, n <= 2};
    endfunction

    // Drives one cycle, updates the reference queue and compares popped words against it.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
        logic fm, em;
        fm = q.size() == 16;
        em = q.size() == 0;
        wr = w; rd = r; w_data = d; err_clr = c;
        if (r && !em) begin
            n_vec++;
            if (r_data !== q[0]) begin
                n_err++;
                $display("FAIL pop: r_data=%h expected=%h", r_data, q[0]);
            end
            void'(q.pop_front());
        end
        if (w && (!fm || r)) q.push_back(d);
        if (ERR) begin
            e_ov = c ? 1'b0 : (e_ov | (w & fm & ~r));
            e_un = c ? 1'b0 : (e_un | (r & em & ~w));
        end
        @(posedge clk);
        #1;
        wr = 0; rd = 0; err_clr = 0;
        e_lvl = lvl_of(q.size());
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({count, full, empty, almost_full, almost_empty} !== lvl_of(0)) begin
            n_err++;
            $display("FAIL reset_level: got=%h expected=%h", {count, full, empty, almost_full, almost_empty}, lvl_of(0));
        end
        n_vec++;
        if ({overflow, underflow} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_err: got=%b expected=00", {overflow, underflow});
        end
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 8'(i), 0);
            n_vec++;
            if ({count, full, empty, almost_full, almost_empty} !== e_lvl) begin
                n_err++;
                $display("FAIL fill_level[%0d]: got=%h expected=%h", i, {count, full, empty, almost_full, almost_empty}, e_lvl);
            end
            n_vec++;
            if (r_data !== 8'h01) begin
                n_err++;
                $display("FAIL fill_head[%0d]: r_data=%h expected=01", i, r_data);
            end
        end
    endtask

    task automatic test_full_rw();
        step(1, 1, 8'hAA, 0);
        n_vec++;
        if ({count, full, r_data} !== {5'd16, 1'b1, 8'h02}) begin
            n_err++;
            $display("FAIL full_rw: got count=%0d full=%b r_data=%h expected 16/1/02", count, full, r_data);
        end
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
        n_vec++;
        if ({count, full, empty, almost_full, almost_empty} !== lvl_of(0)) begin
            n_err++;
            $display("FAIL drain_level: got=%h expected=%h", {count, full, empty, almost_full, almost_empty}, lvl_of(0));
        end
    endtask

    task automatic test_empty_rw();
        step(1, 1, 8'h55, 0);
        n_vec++;
        if ({count, empty, r_data, underflow} !== {5'd1, 1'b0, 8'h55, 1'b0}) begin
            n_err++;
            $display("FAIL empty_rw: got count=%0d empty=%b r_data=%h underflow=%b expected 1/0/55/0", count, empty, r_data, underflow);
        end
        step(0, 1, 8'h00, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            step(1, 0, 8'(8'h30 + i), 0);
            step(0, 1, 8'h00, 0);
        end
        n_vec++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_level: count=%0d empty=%b expected 0/1", count, empty);
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hC0 + i), 0);
        step(1, 0, 8'hEE, 0);
        n_vec++;
        if ({overflow, count} !== {e_ov, 5'd16}) begin
            n_err++;
            $display("FAIL overflow: got ov=%b count=%0d expected %b/16", overflow, count, e_ov);
        end
        step(1, 0, 8'hEF, 1);
        n_vec++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clr_priority: overflow=%b expected 0", overflow);
        end
        step(1, 0, 8'hEE, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        n_vec++;
        if ({overflow, underflow} !== {e_ov, e_un}) begin
            n_err++;
            $display("FAIL underflow: got=%b expected=%b", {overflow, underflow}, {e_ov, e_un});
        end
        step(0, 0, 8'h00, 1);
        n_vec++;
        if ({overflow, underflow} !== 2'b00) begin
            n_err++;
            $display("FAIL err_clr: got=%b expected=00", {overflow, underflow});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h90 + i), 0);
        n_vec++;
        if (count !== 5'd7) begin
            n_err++;
            $display("FAIL mid_pre: count=%0d expected 7", count);
        end
        #2 reset_n = 0;
        #1;
        n_vec++;
        if ({count, full, empty, almost_full, almost_empty} !== lvl_of(0)) begin
            n_err++;
            $display("FAIL mid_reset: got=%h expected=%h", {count, full, empty, almost_full, almost_empty}, lvl_of(0));
        end
        q.delete();
        e_ov = 0;
        e_un = 0;
        #2 reset_n = 1;
        step(1, 0, 8'h77, 0);
        n_vec++;
        if ({count, r_data} !== {5'd1, 8'h77}) begin
            n_err++;
            $display("FAIL post_reset: count=%0d r_data=%h expected 1/77", count, r_data);
        end
        step(0, 1, 8'h00, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_errors();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
